// File: rtl/clkdiv_pkg.sv
// Shared types and default constants for the divider controller.
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEF   = 25;
    localparam int unsigned TICKS_W_DEF = 8;
    localparam int unsigned DEF_DIV_DEF = 10000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

endpackage

// File: rtl/clkdiv_tick_core.sv
// Divider datapath: period counter, terminal-count compare, Tick and ClkOut registers.
module clkdiv_tick_core
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,      // zero counter, drop tick, park clk_out low
    input  logic             en,       // advance counter this cycle
    input  logic [CNT_W-1:0] div,
    output logic             tick,
    output logic             clk_out,
    output logic             hit       // counter at terminal value this cycle
);

    logic [CNT_W-1:0] count;

    // Compare is done before the increment, so div = all-ones never overflows.
    assign hit = (count == div);

    // Counter advances while enabled; terminal count wraps, emits a tick and toggles clk_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (en) begin
            if (hit) begin
                count   <= '0;
                tick    <= 1'b1;
                clk_out <= ~clk_out;
            end else begin
                count   <= count + CNT_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Divider controller: config handshake, run/stop sequencing, burst tracking.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF,
    parameter int unsigned TICKS_W = TICKS_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               CfgValid,
    output logic               CfgReady,
    input  logic [CNT_W-1:0]   CfgDiv,
    input  logic               CfgOneShot,
    input  logic [TICKS_W-1:0] CfgBurst,
    input  logic               Start,
    input  logic               Stop,
    output logic               Busy,
    output logic               Tick,
    output logic               ClkOut,
    output logic [TICKS_W-1:0] TickCnt,
    output logic               Done,
    output logic               CfgErr
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);

    state_e               state_q;
    logic [CNT_W-1:0]     div_q;
    logic                 one_shot_q;
    logic [TICKS_W-1:0]   burst_q;

    logic                 core_clr;
    logic                 core_en;
    logic                 core_hit;
    logic                 cfg_reject;
    logic                 burst_last;

    assign CfgReady = (state_q == IDLE);
    assign Busy     = (state_q != IDLE);

    // A zero divide or an empty burst would never complete sensibly.
    assign cfg_reject = (CfgDiv == '0) || (CfgOneShot && (CfgBurst == '0));

    // Stop clears the core in the same cycle, which suppresses a coinciding tick.
    assign core_en  = (state_q == RUN);
    assign core_clr = (state_q != RUN) || Stop;

    // Tick cycle of the final burst tick: TickCnt has just reached the burst length.
    assign burst_last = Tick && one_shot_q && (TickCnt == burst_q);

    clkdiv_tick_core #(
        .CNT_W (CNT_W)
    ) u_tick_core (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .clr     (core_clr),
        .en      (core_en),
        .div     (div_q),
        .tick    (Tick),
        .clk_out (ClkOut),
        .hit     (core_hit)
    );

    // Control FSM with config registers, tick counter and registered Done/CfgErr pulses.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            div_q      <= DefDiv;
            one_shot_q <= 1'b0;
            burst_q    <= TICKS_W'(1);
            TickCnt    <= '0;
            Done       <= 1'b0;
            CfgErr     <= 1'b0;
        end else begin
            Done   <= 1'b0;
            CfgErr <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Config lands in the same edge as Start, so the run uses it.
                    if (CfgValid) begin
                        if (cfg_reject) begin
                            CfgErr <= 1'b1;
                        end else begin
                            div_q      <= CfgDiv;
                            one_shot_q <= CfgOneShot;
                            burst_q    <= CfgBurst;
                        end
                    end
                    if (Start && !Stop) begin
                        state_q <= RUN;
                        TickCnt <= '0;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        state_q <= IDLE;
                    end else begin
                        if (core_hit) begin
                            TickCnt <= TickCnt + TICKS_W'(1);
                        end
                        if (burst_last) begin
                            state_q <= FINISH;
                            Done    <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl against an arithmetic reference model.
module tb_clkdiv_ctrl;

    localparam int CNT_W   = 25;
    localparam int TICKS_W = 8;
    localparam int DEF_DIV = 10000;

    logic               Clk = 1'b0;
    logic               Rst_n;
    logic               CfgValid;
    logic               CfgReady;
    logic [CNT_W-1:0]   CfgDiv;
    logic               CfgOneShot;
    logic [TICKS_W-1:0] CfgBurst;
    logic               Start;
    logic               Stop;
    logic               Busy;
    logic               Tick;
    logic               ClkOut;
    logic [TICKS_W-1:0] TickCnt;
    logic               Done;
    logic               CfgErr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a run is described by its start cycle and config;
    // all outputs follow from elapsed cycles by division.
    bit     m_busy;
    longint m_sc;
    longint m_div;
    bit     m_os;
    longint m_burst;
    longint m_held;
    bit     m_err;
    longint cyc = 0;

    clkdiv_ctrl u_dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .CfgValid   (CfgValid),
        .CfgReady   (CfgReady),
        .CfgDiv     (CfgDiv),
        .CfgOneShot (CfgOneShot),
        .CfgBurst   (CfgBurst),
        .Start      (Start),
        .Stop       (Stop),
        .Busy       (Busy),
        .Tick       (Tick),
        .ClkOut     (ClkOut),
        .TickCnt    (TickCnt),
        .Done       (Done),
        .CfgErr     (CfgErr)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_sc    = 0;
        m_div   = DEF_DIV;
        m_os    = 1'b0;
        m_burst = 1;
        m_held  = 0;
        m_err   = 1'b0;
    endtask

    task automatic check_outputs();
        longint e, p, n;
        bit     exp_tick, exp_done, exp_clk;
        longint exp_cnt;
        if (!m_busy) begin
            exp_tick = 1'b0;
            exp_done = 1'b0;
            exp_clk  = 1'b0;
            exp_cnt  = m_held;
        end else begin
            e        = cyc - m_sc;
            p        = m_div + 1;
            n        = (e - 1) / p;
            exp_tick = ((e - 1) >= p) && (((e - 1) % p) == 0);
            exp_done = m_os && (e == m_burst * p + 2);
            exp_clk  = (n % 2) == 1;
            exp_cnt  = n % 256;
        end
        check_eq("Tick",     64'(Tick),     64'(exp_tick));
        check_eq("ClkOut",   64'(ClkOut),   64'(exp_clk));
        check_eq("TickCnt",  64'(TickCnt),  64'(exp_cnt));
        check_eq("Done",     64'(Done),     64'(exp_done));
        check_eq("Busy",     64'(Busy),     64'(m_busy));
        check_eq("CfgReady", 64'(CfgReady), 64'(!m_busy));
        check_eq("CfgErr",   64'(CfgErr),   64'(m_err));
    endtask

    task automatic model_update(input logic v, input logic [CNT_W-1:0] d, input logic os,
                                input logic [TICKS_W-1:0] b, input logic st, input logic sp);
        longint e, p;
        bit     next_err;
        next_err = 1'b0;
        if (!m_busy) begin
            if (v) begin
                if (d == 0 || (os && b == 0)) begin
                    next_err = 1'b1;
                end else begin
                    m_div   = longint'(d);
                    m_os    = os;
                    m_burst = longint'(b);
                end
            end
            if (st && !sp) begin
                m_busy = 1'b1;
                m_sc   = cyc;
                m_held = 0;
            end
        end else begin
            e = cyc - m_sc;
            p = m_div + 1;
            if ((m_os && e == m_burst * p + 2) || sp) begin
                m_busy = 1'b0;
                m_held = ((e - 1) / p) % 256;
            end
        end
        m_err = next_err;
        cyc++;
    endtask

    // One clock: check this cycle's outputs, drive inputs, let the edge sample them.
    task automatic run_cycle(input logic v, input logic [CNT_W-1:0] d, input logic os,
                             input logic [TICKS_W-1:0] b, input logic st, input logic sp);
        @(negedge Clk);
        check_outputs();
        CfgValid   = v;
        CfgDiv     = d;
        CfgOneShot = os;
        CfgBurst   = b;
        Start      = st;
        Stop       = sp;
        @(posedge Clk);
        model_update(v, d, os, b, st, sp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        CfgValid = 1'b0; CfgDiv = '0; CfgOneShot = 1'b0; CfgBurst = '0;
        Start = 1'b0; Stop = 1'b0;
        Rst_n = 1'b0;
        #1;
        check_eq("rst_Tick",     64'(Tick),     64'd0);
        check_eq("rst_ClkOut",   64'(ClkOut),   64'd0);
        check_eq("rst_TickCnt",  64'(TickCnt),  64'd0);
        check_eq("rst_Done",     64'(Done),     64'd0);
        check_eq("rst_CfgErr",   64'(CfgErr),   64'd0);
        check_eq("rst_Busy",     64'(Busy),     64'd0);
        check_eq("rst_CfgReady", 64'(CfgReady), 64'd1);
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        CfgValid = 1'b0; CfgDiv = '0; CfgOneShot = 1'b0; CfgBurst = '0;
        Start = 1'b0; Stop = 1'b0;
        Rst_n = 1'b1;
        #2;
        do_reset();
        idle(2);

        // Rejected configs leave the default divide in place.
        run_cycle(1'b1, '0, 1'b0, 8'd1, 1'b0, 1'b0);
        run_cycle(1'b1, 25'd5, 1'b1, 8'd0, 1'b0, 1'b0);
        idle(2);
        // Default period: ticks at 10002, 20003, 30004.
        run_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(30010);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(3);

        // Div=3 periodic with Start in the config cycle; config offered while busy is ignored.
        run_cycle(1'b1, 25'd3, 1'b0, 8'd0, 1'b1, 1'b0);
        idle(9);
        run_cycle(1'b1, '0, 1'b0, 8'd0, 1'b0, 1'b0);
        idle(11);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(5);

        // One-shot burst of 4 at Div=1, then a repeat Start.
        run_cycle(1'b1, 25'd1, 1'b1, 8'd4, 1'b1, 1'b0);
        idle(14);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(14);

        // Start and Stop together in IDLE stays idle.
        run_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        idle(3);

        // Stop on the terminal-count cycle suppresses that tick (first and second period).
        run_cycle(1'b1, 25'd2, 1'b0, 8'd0, 1'b1, 1'b0);
        idle(2);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(4);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(5);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(4);

        // Largest divide: counter runs without wrapping early.
        run_cycle(1'b1, {CNT_W{1'b1}}, 1'b0, 8'd0, 1'b1, 1'b0);
        idle(40);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(2);

        // Randomized traffic with small divides and bursts.
        for (int i = 0; i < 25000; i++) begin
            logic               v, os, st, sp;
            logic [CNT_W-1:0]   d;
            logic [TICKS_W-1:0] b;
            v  = ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
            os = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 9) == 0) ? '0 : TICKS_W'($urandom_range(1, 5));
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 49) == 0);
            run_cycle(v, d, os, b, st, sp);
        end
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(3);

        // Reset mid-burst after three ticks; config reverts to defaults.
        run_cycle(1'b1, 25'd5, 1'b1, 8'd10, 1'b1, 1'b0);
        idle(20);
        do_reset();
        run_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(10004);
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
- Programmable divider controller that sequences the team's divider datapath: it accepts a divide value over a valid/ready config handshake, then runs or stops on command.
- Emits a 1-cycle tick enable plus a 50%-duty square wave, in either periodic or one-shot burst mode.
- Sits between the control/CPU-side register logic and all downstream blocks that need slow enables, such as display refresh and debounce.

Parameters:
- CNT_W, 25, width of divide value and internal counter.
- DEF_DIV, 10000, divide value loaded at reset.
- TICKS_W, 8, width of burst length and tick counter.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- CfgValid  in  1  config offer.
- CfgReady  out  1  config can be accepted; equals (state==IDLE).
- CfgDiv  in  CNT_W  new divide value; tick period = CfgDiv+1 cycles.
- CfgOneShot  in  1  1 = burst mode, 0 = periodic.
- CfgBurst  in  TICKS_W  ticks per burst in one-shot mode.
- Start  in  1  begin running (level sampled).
- Stop  in  1  abort/stop (level sampled).
- Busy  out  1  state != IDLE.
- Tick  out  1  registered 1-cycle pulse per period.
- ClkOut  out  1  square wave; toggles on every Tick.
- TickCnt  out  TICKS_W  ticks issued since last Start; wraps modulo 2^TICKS_W.
- Done  out  1  1-cycle pulse when a one-shot burst completes.
- CfgErr  out  1  1-cycle pulse when an offered config is rejected.

Behaviour:
- Async reset (Rst_n=0):
  - state=IDLE; counter=0; Div=DEF_DIV; OneShot=0; Burst=1.
  - Tick=0, ClkOut=0, TickCnt=0, Done=0, CfgErr=0, Busy=0.
- States: IDLE, RUN, FINISH.
- Config handshake: transfer when CfgValid & CfgReady at a posedge.
  - Reject when CfgDiv==0, or when CfgOneShot=1 and CfgBurst==0. On reject, config registers are unchanged and CfgErr=1 next cycle.
  - CfgReady=1 even on a rejected offer; the offer is consumed.
  - CfgValid outside IDLE is ignored (CfgReady=0 there).
- Config transfer and Start in the same IDLE cycle: the new config is used for that run.
- IDLE:
  - Stop=1 → stay IDLE (Stop wins over Start).
  - Otherwise Start=1 → RUN, counter=0, TickCnt=0, ClkOut=0.
- RUN:
  - Counter increments each cycle.
  - When counter==Div: counter←0, Tick←1 next cycle, ClkOut toggles, TickCnt++.
  - Otherwise Tick←0.
- Latency: cycle 0 is the cycle Start is sampled. First Tick is high in cycle Div+2; later Ticks every Div+1 cycles; ClkOut period is 2*(Div+1) cycles.
- One-shot mode: after the tick that makes TickCnt==Burst, go to FINISH.
  - FINISH lasts 1 cycle with Done=1, then IDLE.
  - Tick and Done never overlap: Done follows the last Tick by 1 cycle.
- Stop in RUN: next state IDLE; no Done.
  - If Stop coincides with counter==Div, the tick is suppressed.
  - TickCnt holds its last value.
- Start in RUN or FINISH: ignored. Stop in FINISH: ignored; Done still pulses.
- Entry to IDLE forces ClkOut=0 and Tick=0.
- Counter comparison is unsigned CNT_W-bit; Div=2^CNT_W-1 must work with no overflow.
- Reset mid-run: immediate return to reset values; Div returns to DEF_DIV, so the previous config is lost.

Decomposition:
- Package clkdiv_pkg holds:
  - state enum {IDLE, RUN, FINISH}.
  - CNT_W/TICKS_W default constants.
  - DEF_DIV constant.
- One sub-module, clkdiv_tick_core: counter + compare + Tick/ClkOut registers, with inputs clr, en, div.
- FSM, config registers and TickCnt stay in the top.

Test Plan:
- Reset, no config, Start pulse → first Tick in cycle 10002, next Ticks at 20003 and 30004; ClkOut toggles at each; TickCnt=3 after the third.
- Config Div=3, periodic, Start → Tick every 4 cycles, ClkOut period 8 cycles; Stop after TickCnt=5 → Busy=0 next cycle, no further Ticks, ClkOut=0, TickCnt holds 5.
- Config Div=1, OneShot=1, Burst=4, Start → exactly 4 Ticks 2 cycles apart, Done 1 cycle after the 4th Tick, then IDLE; repeat Start reproduces it.
- Config Div=0 → CfgErr pulse, Div unchanged (next run still period 10001); config OneShot=1, Burst=0 → CfgErr; CfgValid while Busy → CfgReady=0, no change.
- Start and Stop high together in IDLE → stays IDLE. Stop on the exact counter==Div cycle with Div=2 → no Tick that period.
- Rst_n low mid-burst (Div=5, Burst=10, after 3 Ticks) → all outputs 0 immediately; after release, Start yields period 10001, periodic mode.
